// File: rtl/ej32_ss_if.sv
// eJ32 data-stack bus: the core (master) drives op/vi, and the stack (slave)
// returns the top cell plus its occupancy/status flags.
interface ej32_ss_if #(
  parameter int DEPTH = 64,
  parameter int DW    = 32
);
  logic [2:0]              op;
  logic [DW-1:0]           vi;
  logic [DW-1:0]           s;
  logic [$clog2(DEPTH):0]  sp;
  logic                    empty;
  logic                    full;
  logic                    err;

  modport master (
    output op, vi,
    input  s, sp, empty, full, err
  );

  modport slave (
    input  op, vi,
    output s, sp, empty, full, err
  );
endinterface

// File: rtl/ej32_ss_modport.sv
// eJ32 data stack, slave side: holds the cells below the core's TOS register.
// The top cell is visible combinationally, so a pop has zero read latency.
module ej32_ss_modport #(
  parameter int DEPTH = 64,
  parameter int DW    = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  ej32_ss_if.slave  ss
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_REPL = 3'd3,
    OP_CLR  = 3'd4
  } stack_op_e;

  logic [DW-1:0] mem_q [DEPTH];
  logic [SW-1:0] sp_q;
  logic [SW-1:0] sp_d;
  logic          err_q;
  logic          err_d;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [AW-1:0] top_addr_s;
  logic          empty_s;
  logic          full_s;

  assign empty_s    = (sp_q == {SW{1'b0}});
  assign full_s     = (sp_q == SW'(DEPTH));
  assign top_addr_s = AW'(sp_q - SW'(1));

  // Next-state decode: illegal requests (push when full, pop/repl when empty)
  // leave sp and the array untouched and only raise the sticky error.
  always_comb begin
    sp_d      = sp_q;
    err_d     = err_q;
    wr_en_s   = 1'b0;
    wr_addr_s = top_addr_s;
    case (ss.op)
      OP_PUSH: begin
        if (full_s) begin
          err_d = 1'b1;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = AW'(sp_q);
          sp_d      = sp_q + SW'(1);
        end
      end
      OP_POP: begin
        if (empty_s) begin
          err_d = 1'b1;
        end else begin
          sp_d = sp_q - SW'(1);
        end
      end
      OP_REPL: begin
        if (empty_s) begin
          err_d = 1'b1;
        end else begin
          wr_en_s = 1'b1;
        end
      end
      OP_CLR: begin
        sp_d = {SW{1'b0}};
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
  end

  // Pointer and sticky error; only reset clears err.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= {SW{1'b0}};
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Cell storage is deliberately not reset; contents above sp are don't-care.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= ss.vi;
    end
  end

  assign ss.s     = empty_s ? {DW{1'b0}} : mem_q[top_addr_s];
  assign ss.sp    = sp_q;
  assign ss.empty = empty_s;
  assign ss.full  = full_s;
  assign ss.err   = err_q;

endmodule

// File: tb/tb_ej32_ss_modport.sv
// Directed bench for ej32_ss_modport: LIFO order, fill/overflow, underflow,
// REPL/CLR/illegal ops and asynchronous reset, against hand-computed values.
module tb_ej32_ss_modport;

  localparam int DEPTH = 64;
  localparam int DW    = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ej32_ss_if #(.DEPTH(DEPTH), .DW(DW)) ss_bus ();

  ej32_ss_modport #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ss     (ss_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one op for exactly one clock edge, then return to NOP; sample at +1.
  task automatic step(input logic [2:0] op, input logic [31:0] v);
    ss_bus.op = op;
    ss_bus.vi = v;
    @(posedge clk);
    #1;
    ss_bus.op = 3'd0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    ss_bus.op = 3'd1;
    ss_bus.vi = 32'h1234;

    // Reset held while PUSH is requested every cycle
    for (int i = 0; i < 4; i++) begin
      ss_bus.vi = 32'(i + 100);
      @(posedge clk);
      #1;
      chk("rst_sp", 64'(ss_bus.sp), 64'd0);
      chk("rst_empty", 64'(ss_bus.empty), 64'd1);
      chk("rst_s", 64'(ss_bus.s), 64'd0);
      chk("rst_err", 64'(ss_bus.err), 64'd0);
    end
    ss_bus.op = 3'd0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_empty", 64'(ss_bus.empty), 64'd1);
    chk("rel_full", 64'(ss_bus.full), 64'd0);

    // LIFO
    step(3'd1, 32'd1);
    step(3'd1, 32'd2);
    step(3'd1, 32'd3);
    chk("lifo_s", 64'(ss_bus.s), 64'd3);
    chk("lifo_sp", 64'(ss_bus.sp), 64'd3);
    chk("pop0_s", 64'(ss_bus.s), 64'd3);
    step(3'd2, 32'd0);
    chk("pop1_s", 64'(ss_bus.s), 64'd2);
    step(3'd2, 32'd0);
    chk("pop2_s", 64'(ss_bus.s), 64'd1);
    step(3'd2, 32'd0);
    chk("lifo_empty", 64'(ss_bus.empty), 64'd1);
    chk("lifo_s0", 64'(ss_bus.s), 64'd0);
    chk("lifo_err", 64'(ss_bus.err), 64'd0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      step(3'd1, 32'(i));
    end
    chk("fill_full", 64'(ss_bus.full), 64'd1);
    chk("fill_sp", 64'(ss_bus.sp), 64'd64);
    chk("fill_s", 64'(ss_bus.s), 64'd63);
    chk("fill_err", 64'(ss_bus.err), 64'd0);
    step(3'd1, 32'hDEAD);
    chk("ovf_sp", 64'(ss_bus.sp), 64'd64);
    chk("ovf_s", 64'(ss_bus.s), 64'd63);
    chk("ovf_err", 64'(ss_bus.err), 64'd1);
    step(3'd2, 32'd0);
    chk("unfull_sp", 64'(ss_bus.sp), 64'd63);
    chk("unfull_s", 64'(ss_bus.s), 64'd62);
    chk("unfull_full", 64'(ss_bus.full), 64'd0);

    // Underflow, err is sticky through push and CLR
    pulse_reset();
    chk("uf_pre_err", 64'(ss_bus.err), 64'd0);
    step(3'd2, 32'd0);
    chk("uf_sp", 64'(ss_bus.sp), 64'd0);
    chk("uf_err", 64'(ss_bus.err), 64'd1);
    chk("uf_s", 64'(ss_bus.s), 64'd0);
    step(3'd1, 32'h55);
    chk("uf_push_s", 64'(ss_bus.s), 64'h55);
    chk("uf_push_err", 64'(ss_bus.err), 64'd1);
    step(3'd4, 32'd0);
    chk("clr_keep_err", 64'(ss_bus.err), 64'd1);

    // REPL / CLR / illegal op
    pulse_reset();
    step(3'd3, 32'd9);
    chk("repl_empty_err", 64'(ss_bus.err), 64'd1);
    chk("repl_empty_sp", 64'(ss_bus.sp), 64'd0);
    step(3'd1, 32'd7);
    step(3'd3, 32'd9);
    chk("repl_s", 64'(ss_bus.s), 64'd9);
    chk("repl_sp", 64'(ss_bus.sp), 64'd1);
    step(3'd4, 32'd0);
    chk("clr_sp", 64'(ss_bus.sp), 64'd0);
    chk("clr_empty", 64'(ss_bus.empty), 64'd1);
    step(3'd1, 32'h12);
    step(3'd6, 32'h99);
    chk("ill_sp", 64'(ss_bus.sp), 64'd1);
    chk("ill_s", 64'(ss_bus.s), 64'h12);

    // Mid-stream asynchronous reset
    pulse_reset();
    for (int i = 1; i <= 5; i++) begin
      step(3'd1, 32'(i));
    end
    chk("mid_pre_sp", 64'(ss_bus.sp), 64'd5);
    ss_bus.op = 3'd1;
    ss_bus.vi = 32'd6;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_async_sp", 64'(ss_bus.sp), 64'd0);
    chk("mid_async_empty", 64'(ss_bus.empty), 64'd1);
    @(posedge clk);
    #1;
    chk("mid_hold_sp", 64'(ss_bus.sp), 64'd0);
    ss_bus.op = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd1, 32'hA);
    chk("resume_sp", 64'(ss_bus.sp), 64'd1);
    chk("resume_s", 64'(ss_bus.s), 64'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
